wb_statis: RTL

- Per-frame white-balance statistics stage, directly downstream of the Bayer colour-flag stage.
- Consumes aligned fval/lval/pixel data plus one-hot R/G/B flags.
- Inside a programmable ROI window it accumulates the per-colour pixel sums and per-colour pixel counts.
- At frame end it presents registered results with a one-cycle valid pulse to the WB gain calculation / register bank.

---
 rtl/wb_statis_if.sv | 31 +++
 rtl/wb_statis.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/wb_statis_if.sv
// Video-in / statistics-out bundle for wb_statis.
// The master drives timing, pixel data and colour flags; the slave returns the frame results.
interface wb_statis_if #(
  parameter int unsigned SENSOR_DAT_WIDTH = 10,
  parameter int unsigned SUM_WIDTH        = 32,
  parameter int unsigned NUM_WIDTH        = 24
);
  logic                        i_fval;
  logic                        i_lval;
  logic [SENSOR_DAT_WIDTH-1:0] iv_pix_data;
  logic                        i_r_flag;
  logic                        i_g_flag;
  logic                        i_b_flag;
  logic [SUM_WIDTH-1:0]        ov_r_sum;
  logic [SUM_WIDTH-1:0]        ov_g_sum;
  logic [SUM_WIDTH-1:0]        ov_b_sum;
  logic [NUM_WIDTH-1:0]        ov_r_num;
  logic [NUM_WIDTH-1:0]        ov_g_num;
  logic [NUM_WIDTH-1:0]        ov_b_num;
  logic                        o_stat_valid;

  modport master (
    output i_fval, i_lval, iv_pix_data, i_r_flag, i_g_flag, i_b_flag,
    input  ov_r_sum, ov_g_sum, ov_b_sum, ov_r_num, ov_g_num, ov_b_num, o_stat_valid
  );

  modport slave (
    input  i_fval, i_lval, iv_pix_data, i_r_flag, i_g_flag, i_b_flag,
    output ov_r_sum, ov_g_sum, ov_b_sum, ov_r_num, ov_g_num, ov_b_num, o_stat_valid
  );
endinterface

// File: rtl/wb_statis.sv
// Per-frame white-balance statistics: ROI-windowed per-colour pixel sums and counts.
// Define WB_SAT_EXCLUDE_EN to drop pixels at or above SAT_VALUE from the statistics.
module wb_statis #(
  parameter int unsigned SENSOR_DAT_WIDTH = 10,
  parameter int unsigned REG_WD           = 16,
  parameter int unsigned SUM_WIDTH        = 32,
  parameter int unsigned NUM_WIDTH        = 24,
  parameter int unsigned SAT_VALUE        = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_WD-1:0] iv_offset_x,
  input  logic [REG_WD-1:0] iv_offset_y,
  input  logic [REG_WD-1:0] iv_width,
  input  logic [REG_WD-1:0] iv_height,
  wb_statis_if.slave        bus
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e state_q, state_d;

  logic              fval_dly, lval_dly;
  logic              fval_rise, fval_fall, lval_fall, frame_start;
  logic [REG_WD-1:0] col_cnt, row_cnt;
  logic [REG_WD-1:0] off_x_q, off_y_q, width_q, height_q;
  logic [REG_WD:0]   x_end, y_end;
  logic              in_win, one_hot, pix_keep, acc_en;
  logic [2:0]        flags, hit;

  // Index 0 = R, 1 = G, 2 = B throughout.
  logic [SUM_WIDTH-1:0] sum_q     [3];
  logic [NUM_WIDTH-1:0] num_q     [3];
  logic [SUM_WIDTH-1:0] sum_nxt   [3];
  logic [NUM_WIDTH-1:0] num_nxt   [3];
  logic [SUM_WIDTH:0]   sum_wide  [3];
  logic [SUM_WIDTH-1:0] out_sum_q [3];
  logic [NUM_WIDTH-1:0] out_num_q [3];
  logic                 stat_valid_q;
  logic [SUM_WIDTH:0]   pix_ext;

  assign fval_rise   = bus.i_fval & ~fval_dly;
  assign fval_fall   = ~bus.i_fval & fval_dly;
  assign lval_fall   = ~bus.i_lval & lval_dly;
  assign frame_start = fval_rise & (state_q != StAccum);

  // One extra bit so offset + size never wraps back into range.
  assign x_end  = {1'b0, off_x_q} + {1'b0, width_q};
  assign y_end  = {1'b0, off_y_q} + {1'b0, height_q};
  assign in_win = (col_cnt >= off_x_q) && ({1'b0, col_cnt} < x_end) &&
                  (row_cnt >= off_y_q) && ({1'b0, row_cnt} < y_end);

  assign flags   = {bus.i_b_flag, bus.i_g_flag, bus.i_r_flag};
  assign one_hot = (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);

`ifdef WB_SAT_EXCLUDE_EN
  assign pix_keep = 32'(bus.iv_pix_data) < SAT_VALUE;
`else
  logic unused_sat_value;
  assign unused_sat_value = ^SAT_VALUE;
  assign pix_keep         = 1'b1;
`endif

  assign acc_en  = (state_q == StAccum) && bus.i_fval && bus.i_lval && in_win && one_hot &&
                   pix_keep;
  assign hit     = acc_en ? flags : 3'b000;
  assign pix_ext = {{(SUM_WIDTH + 1 - SENSOR_DAT_WIDTH){1'b0}}, bus.iv_pix_data};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sum_wide[i] = {1'b0, sum_q[i]} + pix_ext;
      sum_nxt[i]  = sum_wide[i][SUM_WIDTH] ? '1 : sum_wide[i][SUM_WIDTH-1:0];
      num_nxt[i]  = (num_q[i] == '1) ? num_q[i] : num_q[i] + NUM_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (fval_rise) state_d = StAccum;
      StAccum: if (fval_fall) state_d = StDone;
      StDone:  state_d = fval_rise ? StAccum : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      // Track fval during reset so a frame already in flight is not seen as a new rise.
      fval_dly     <= bus.i_fval;
      lval_dly     <= 1'b0;
      col_cnt      <= '0;
      row_cnt      <= '0;
      off_x_q      <= '0;
      off_y_q      <= '0;
      width_q      <= '0;
      height_q     <= '0;
      stat_valid_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        sum_q[i]     <= '0;
        num_q[i]     <= '0;
        out_sum_q[i] <= '0;
        out_num_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      fval_dly <= bus.i_fval;
      lval_dly <= bus.i_lval;

      if (!bus.i_lval)        col_cnt <= '0;
      else if (col_cnt != '1) col_cnt <= col_cnt + REG_WD'(1);

      if (!bus.i_fval)                    row_cnt <= '0;
      else if (lval_fall && row_cnt != '1) row_cnt <= row_cnt + REG_WD'(1);

      if (frame_start) begin
        off_x_q  <= iv_offset_x;
        off_y_q  <= iv_offset_y;
        width_q  <= iv_width;
        height_q <= iv_height;
      end

      for (int i = 0; i < 3; i++) begin
        if (frame_start) begin
          sum_q[i] <= '0;
          num_q[i] <= '0;
        end else if (hit[i]) begin
          sum_q[i] <= sum_nxt[i];
          num_q[i] <= num_nxt[i];
        end
      end

      stat_valid_q <= (state_q == StDone);
      if (state_q == StDone) begin
        for (int i = 0; i < 3; i++) begin
          out_sum_q[i] <= sum_q[i];
          out_num_q[i] <= num_q[i];
        end
      end
    end
  end

  assign bus.ov_r_sum     = out_sum_q[0];
  assign bus.ov_g_sum     = out_sum_q[1];
  assign bus.ov_b_sum     = out_sum_q[2];
  assign bus.ov_r_num     = out_num_q[0];
  assign bus.ov_g_num     = out_num_q[1];
  assign bus.ov_b_num     = out_num_q[2];
  assign bus.o_stat_valid = stat_valid_q;

endmodule
